// File: rtl/flash_pkg.sv
// Shared flash driver definitions: scheduler state encoding and command codes.
// Imported by the read scheduler and by the QSPI driver.
package flash_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CHECK,
      ST_ISSUE,
      ST_WAIT,
      ST_NEXT,
      ST_FIN,
      ST_ERR
   } state_e;

   localparam logic [4:0] CMD_IDLE      = 5'd0;
   localparam logic [4:0] CMD_READ_TYPE = 5'd8;
   localparam logic [7:0] CMD_READ_CODE = 8'h6B;

endpackage

// File: rtl/flash_read_sched.sv
// Flash dump scheduler: issues page reads to the QSPI driver with FIFO back-pressure.
// Optional watchdog on WAIT enabled by FLASH_READ_SCHED_TIMEOUT_EN.
module flash_read_sched
   import flash_pkg::*;
#(
   parameter int unsigned PAGE_BYTES    = 256,
   parameter int unsigned FIFO_DEPTH    = 2048,
   parameter logic [4:0]  READ_CMD_TYPE = CMD_READ_TYPE,
   parameter logic [7:0]  READ_CMD_CODE = CMD_READ_CODE,
   parameter int unsigned TIMEOUT_CYC   = 65535
) (
   input  logic        clk_25M,
   input  logic        rst,
   input  logic        I_start,
   input  logic        I_abort,
   input  logic [23:0] I_start_addr,
   input  logic [15:0] I_len_pages,
   input  logic        I_done_sig,
   input  logic        I_read_byte_valid,
   input  logic [10:0] I_wr_data_count,
   output logic [4:0]  O_cmd_type,
   output logic [7:0]  O_cmd_code,
   output logic [23:0] O_qspi_addr,
   output logic        O_busy,
   output logic        O_done,
   output logic        O_err
);

   localparam logic [10:0] FILL_LIM = 11'(FIFO_DEPTH - 2 * PAGE_BYTES);
   localparam logic [23:0] PAGE_INC = 24'(PAGE_BYTES);
   localparam logic [9:0]  PAGE_CNT = 10'(PAGE_BYTES);

   state_e      state_q, state_d;
   logic [23:0] addr_q, addr_d;
   logic [15:0] pages_q, pages_d;
   logic [8:0]  bcnt_q, bcnt_d;
   logic        abort_q, abort_d;
   logic        err_q, err_d;
   logic [9:0]  bcnt_sum;
   logic        cmd_act;
   logic        unused_addr_lo;

   assign unused_addr_lo = ^I_start_addr[7:0];

`ifdef FLASH_READ_SCHED_TIMEOUT_EN
   // ERR lands TIMEOUT_CYC cycles after the ISSUE cycle
   localparam logic [15:0] WDOG_LIM = 16'(TIMEOUT_CYC - 2);
   logic [15:0] wdog_q, wdog_d;
`else
   localparam int unsigned unused_timeout = TIMEOUT_CYC;
`endif

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      pages_d  = pages_q;
      bcnt_d   = bcnt_q;
      abort_d  = abort_q;
      err_d    = err_q;
      bcnt_sum = {1'b0, bcnt_q} + 10'(I_read_byte_valid);
`ifdef FLASH_READ_SCHED_TIMEOUT_EN
      wdog_d   = wdog_q;
`endif
      if (state_q != ST_IDLE && I_abort) begin
         abort_d = 1'b1;
      end
      unique case (state_q)
         ST_IDLE: begin
            abort_d = 1'b0;
            if (I_start) begin
               state_d = ST_CHECK;
               addr_d  = {I_start_addr[23:8], 8'h00};
               pages_d = I_len_pages;
               err_d   = 1'b0;
            end
         end
         ST_CHECK: begin
            if (pages_q == 16'd0 || abort_q) begin
               state_d = ST_FIN;
            end else if (I_wr_data_count <= FILL_LIM) begin
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            bcnt_d  = 9'd0;
`ifdef FLASH_READ_SCHED_TIMEOUT_EN
            wdog_d  = 16'd0;
`endif
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            bcnt_d = bcnt_sum[8:0];
`ifdef FLASH_READ_SCHED_TIMEOUT_EN
            wdog_d = wdog_q + 16'd1;
`endif
            if (I_done_sig) begin
               if (bcnt_sum == PAGE_CNT) begin
                  state_d = ST_NEXT;
               end else begin
                  state_d = ST_ERR;
                  err_d   = 1'b1;
               end
`ifdef FLASH_READ_SCHED_TIMEOUT_EN
            end else if (wdog_q == WDOG_LIM) begin
               state_d = ST_ERR;
               err_d   = 1'b1;
`endif
            end
         end
         ST_NEXT: begin
            addr_d  = addr_q + PAGE_INC;
            pages_d = pages_q - 16'd1;
            state_d = ST_CHECK;
         end
         ST_FIN:  state_d = ST_IDLE;
         ST_ERR:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_25M) begin
      if (rst) begin
         state_q <= ST_IDLE;
         addr_q  <= 24'd0;
         pages_q <= 16'd0;
         bcnt_q  <= 9'd0;
         abort_q <= 1'b0;
         err_q   <= 1'b0;
`ifdef FLASH_READ_SCHED_TIMEOUT_EN
         wdog_q  <= 16'd0;
`endif
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         pages_q <= pages_d;
         bcnt_q  <= bcnt_d;
         abort_q <= abort_d;
         err_q   <= err_d;
`ifdef FLASH_READ_SCHED_TIMEOUT_EN
         wdog_q  <= wdog_d;
`endif
      end
   end

   // Command fields decode straight from state so they hold through WAIT
   assign cmd_act     = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
   assign O_cmd_type  = cmd_act ? READ_CMD_TYPE : CMD_IDLE;
   assign O_cmd_code  = cmd_act ? READ_CMD_CODE : 8'h00;
   assign O_qspi_addr = cmd_act ? addr_q : 24'h000000;
   assign O_busy      = (state_q != ST_IDLE);
   assign O_done      = (state_q == ST_FIN) || (state_q == ST_ERR);
   assign O_err       = err_q;

endmodule

// File: tb/tb_flash_read_sched.sv
// Directed bench for flash_read_sched with an address scoreboard and driver model.
// Timeout case runs only when FLASH_READ_SCHED_TIMEOUT_EN is defined.
module tb_flash_read_sched;
   import flash_pkg::*;

   localparam int PB = 256;
`ifdef FLASH_READ_SCHED_TIMEOUT_EN
   localparam int TMO = 100;
`else
   localparam int TMO = 65535;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        st = 1'b0;
   logic        ab = 1'b0;
   logic        dn = 1'b0;
   logic        bv = 1'b0;
   logic [23:0] sa = '0;
   logic [15:0] ln = '0;
   logic [10:0] wc = '0;
   logic [4:0]  ct;
   logic [7:0]  cc;
   logic [23:0] qa;
   logic        busy, done, err;

   int n_chk = 0;
   int n_fail = 0;
   logic [23:0] exp_q[$];

   always #20 clk = ~clk;

   flash_read_sched #(
      .TIMEOUT_CYC(TMO)
   ) dut (
      .clk_25M(clk),
      .rst(rst),
      .I_start(st),
      .I_abort(ab),
      .I_start_addr(sa),
      .I_len_pages(ln),
      .I_done_sig(dn),
      .I_read_byte_valid(bv),
      .I_wr_data_count(wc),
      .O_cmd_type(ct),
      .O_cmd_code(cc),
      .O_qspi_addr(qa),
      .O_busy(busy),
      .O_done(done),
      .O_err(err)
   );

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic start_dump(input logic [23:0] a, input logic [15:0] n,
                             input int npush);
      logic [23:0] base;
      base = {a[23:8], 8'h00};
      for (int i = 0; i < npush; i++)
         exp_q.push_back(base + 24'(i * PB));
      sa = a;
      ln = n;
      st = 1'b1;
      tick();
      st = 1'b0;
   endtask

   task automatic wait_issue(input string tag, input int maxc,
                             output int waited, output logic [23:0] a);
      waited = 0;
      a = '0;
      while (ct !== 5'd8 && waited < maxc) begin
         tick();
         waited++;
      end
      chk({tag, "_issue"}, 64'(ct), 64'd8);
      if (ct === 5'd8) begin
         chk({tag, "_code"}, 64'(cc), 64'h6B);
         chk({tag, "_sb"}, 64'(exp_q.size() > 0), 64'd1);
         if (exp_q.size() > 0) begin
            a = exp_q.pop_front();
            chk({tag, "_addr"}, 64'(qa), 64'(a));
         end
      end
   endtask

   // Driver model: nb strobes, done either with the last strobe or after it
   task automatic serve(input string tag, input int nb, input bit dn_last,
                        input int abort_at, input logic [23:0] a);
      bit bad;
      bad = 1'b0;
      tick();
      for (int i = 0; i < nb; i++) begin
         if (ct !== 5'd8 || qa !== a) bad = 1'b1;
         bv = 1'b1;
         ab = (i == abort_at);
         if (dn_last && i == nb - 1) dn = 1'b1;
         tick();
      end
      ab = 1'b0;
      if (!dn_last) begin
         if (ct !== 5'd8 || qa !== a) bad = 1'b1;
         bv = 1'b0;
         dn = 1'b1;
         tick();
      end
      bv = 1'b0;
      dn = 1'b0;
      chk({tag, "_hold"}, 64'(bad), 64'd0);
   endtask

   task automatic wait_done(input string tag, input int maxc,
                            input int exp_cyc, input logic exp_err);
      int cyc;
      int iss;
      cyc = 0;
      iss = 0;
      while (done !== 1'b1 && cyc < maxc) begin
         if (ct !== 5'd0) iss++;
         tick();
         cyc++;
      end
      chk({tag, "_done"}, 64'(done), 64'd1);
      chk({tag, "_done_lat"}, 64'(cyc), 64'(exp_cyc));
      chk({tag, "_no_issue"}, 64'(iss), 64'd0);
      tick();
      chk({tag, "_done_pulse"}, 64'(done), 64'd0);
      chk({tag, "_idle"}, 64'(busy), 64'd0);
      chk({tag, "_err"}, 64'(err), 64'(exp_err));
   endtask

   initial begin
      int w;
      int k;
      logic [23:0] a;

      tick();
      tick();
      chk("reset_outs", 64'({ct, cc, qa, busy, done, err}), 64'd0);
      rst = 1'b0;
      tick();

      // three pages from an unaligned start address
      start_dump(24'h000123, 16'd3, 3);
      chk("s1_busy", 64'(busy), 64'd1);
      chk("s1_check_idle_cmd", 64'(ct), 64'd0);
      wait_issue("s1p0", 20, w, a);
      chk("s1_start_lat", 64'(w), 64'd1);
      serve("s1p0", PB, 1'b0, -1, a);
      chk("s1_next_cmd", 64'(ct), 64'd0);
      chk("s1_next_busy", 64'(busy), 64'd1);
      wait_issue("s1p1", 20, w, a);
      chk("s1_next_lat", 64'(w), 64'd2);
      serve("s1p1", PB, 1'b0, -1, a);
      wait_issue("s1p2", 20, w, a);
      serve("s1p2", PB, 1'b1, -1, a);
      wait_done("s1", 20, 2, 1'b0);

      // address wrap at top of flash
      start_dump(24'hFFFF00, 16'd2, 2);
      wait_issue("s2p0", 20, w, a);
      serve("s2p0", PB, 1'b0, -1, a);
      wait_issue("s2p1", 20, w, a);
      chk("s2_wrap", 64'(a), 64'h000000);
      serve("s2p1", PB, 1'b0, -1, a);
      wait_done("s2", 20, 2, 1'b0);

      // FIFO back-pressure, then the exact threshold
      wc = 11'd1600;
      start_dump(24'h001000, 16'd1, 1);
      k = 0;
      for (int i = 0; i < 50; i++) begin
         if (ct !== 5'd0) k++;
         tick();
      end
      chk("s3_bp_1600", 64'(k), 64'd0);
      wc = 11'd1537;
      k = 0;
      for (int i = 0; i < 5; i++) begin
         if (ct !== 5'd0) k++;
         tick();
      end
      chk("s3_bp_1537", 64'(k), 64'd0);
      wc = 11'd1536;
      wait_issue("s3p0", 20, w, a);
      chk("s3_release_lat", 64'(w), 64'd1);
      wc = 11'd1000;
      serve("s3p0", PB, 1'b0, -1, a);
      wait_done("s3", 20, 2, 1'b0);
      wc = 11'd0;

      // short page -> error, cleared by next start
      start_dump(24'h002000, 16'd2, 1);
      wait_issue("s4p0", 20, w, a);
      serve("s4p0", PB - 1, 1'b0, -1, a);
      chk("s4_err", 64'(err), 64'd1);
      chk("s4_done", 64'(done), 64'd1);
      chk("s4_err_cmd", 64'(ct), 64'd0);
      tick();
      chk("s4_idle", 64'(busy), 64'd0);
      chk("s4_err_sticky", 64'(err), 64'd1);
      chk("s4_done_pulse", 64'(done), 64'd0);
      start_dump(24'h003000, 16'd1, 1);
      chk("s4_err_clear", 64'(err), 64'd0);
      wait_issue("s4p1", 20, w, a);
      serve("s4p1", PB, 1'b0, -1, a);
      wait_done("s4b", 20, 2, 1'b0);

      // abort during page 1 of 4
      start_dump(24'h004000, 16'd4, 1);
      wait_issue("s5p0", 20, w, a);
      serve("s5p0", PB, 1'b0, 100, a);
      wait_done("s5", 20, 2, 1'b0);
      chk("s5_sb_drain", 64'(exp_q.size()), 64'd0);

      // reset in the middle of WAIT
      start_dump(24'h005000, 16'd2, 2);
      wait_issue("s6p0", 20, w, a);
      tick();
      bv = 1'b1;
      tick();
      tick();
      rst = 1'b1;
      tick();
      chk("s6_rst_outs", 64'({ct, cc, qa, busy, done, err}), 64'd0);
      rst = 1'b0;
      bv = 1'b0;
      exp_q.delete();
      tick();
      start_dump(24'h006000, 16'd1, 1);
      wait_issue("s6p1", 20, w, a);
      chk("s6_restart_lat", 64'(w), 64'd1);
      serve("s6p1", PB, 1'b0, -1, a);
      wait_done("s6", 20, 2, 1'b0);

      // zero-length dump
      start_dump(24'h007000, 16'd0, 0);
      wait_done("s7", 20, 1, 1'b0);

`ifdef FLASH_READ_SCHED_TIMEOUT_EN
      // driver never completes
      start_dump(24'h008000, 16'd1, 1);
      wait_issue("s8p0", 20, w, a);
      k = 0;
      while (err !== 1'b1 && k < 200) begin
         tick();
         k++;
      end
      chk("s8_tmo_lat", 64'(k), 64'(TMO));
      chk("s8_tmo_done", 64'(done), 64'd1);
      tick();
      chk("s8_tmo_idle", 64'(busy), 64'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
